// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the memory arbiter: FSM state encoding,
// grant encoding and default block-bus widths.
package memory_arbiter_pkg;

    localparam int DEF_ADDR_W  = 28;
    localparam int DEF_BLOCK_W = 128;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/memory_arbiter_if.sv
// Block-transfer bus between a requester and a responder. One instance per
// cache port and one for the shared memory port.
interface memory_arbiter_if
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int BLOCK_W = DEF_BLOCK_W
);
    logic               read;
    logic               write;
    logic [ADDR_W-1:0]  address;
    logic [BLOCK_W-1:0] writedata;
    logic [BLOCK_W-1:0] readdata;
    logic               busywait;

    modport master (
        output read, write, address, writedata,
        input  readdata, busywait
    );

    modport slave (
        input  read, write, address, writedata,
        output readdata, busywait
    );
endinterface

// File: rtl/memory_arbiter_priority_select.sv
// Tie-break between simultaneous icache and dcache requests.
// ARB_ROUND_ROBIN_EN: alternate on ties; otherwise the dcache always wins.
module arb_priority_select
    import memory_arbiter_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  grant_e last_grant,
    output grant_e grant_next
);

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority has no use for history; the sink keeps the port visible.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // NOTE: the default assignment first guarantees no latch on any path.
    always_comb begin
        grant_next = GRANT_I;
        if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_next = (last_grant == GRANT_D) ? GRANT_I : GRANT_D;
`else
            grant_next = GRANT_D;
`endif
        end else if (d_req) begin
            grant_next = GRANT_D;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one memory block port between icache refills and dcache refills or
// write-backs. Tie policy selected by ARB_ROUND_ROBIN_EN (see arb_priority_select).
module memory_arbiter
    import memory_arbiter_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    memory_arbiter_if.slave  icache,
    memory_arbiter_if.slave  dcache,
    memory_arbiter_if.master mem
);

    arb_state_e state_q, state_d;
    grant_e     grant_q, grant_d;
    grant_e     last_grant_q, last_grant_d;
    grant_e     grant_pick;

    logic i_req;
    logic d_req;
    logic mem_done;

    assign i_req    = icache.read;
    assign d_req    = dcache.read | dcache.write;
    assign mem_done = (state_q == ARB_WAIT) && !mem.busywait;

    arb_priority_select u_priority_select (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant_q),
        .grant_next (grant_pick)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            grant_q      <= GRANT_I;
            last_grant_q <= GRANT_I;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ARB_IDLE: begin
                if (i_req || d_req) begin
                    grant_d = grant_pick;
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: state_d = ARB_WAIT;
            ARB_WAIT: begin
                if (!mem.busywait) begin
                    last_grant_d = grant_q;
                    state_d      = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // The memory port follows the granted requester's live inputs while a transfer is open.
    always_comb begin
        mem.read      = 1'b0;
        mem.write     = 1'b0;
        mem.address   = '0;
        mem.writedata = '0;
        case (state_q)
            ARB_ISSUE, ARB_WAIT: begin
                if (grant_q == GRANT_D) begin
                    mem.read      = dcache.read;
                    mem.write     = dcache.write;
                    mem.address   = dcache.address;
                    mem.writedata = dcache.writedata;
                end else begin
                    mem.read      = icache.read;
                    mem.address   = icache.address;
                    mem.writedata = icache.writedata;
                end
            end
            default: ;
        endcase
        icache.busywait = i_req & ~((grant_q == GRANT_I) & mem_done);
        dcache.busywait = d_req & ~((grant_q == GRANT_D) & mem_done);
    end

    assign icache.readdata = mem.readdata;
    assign dcache.readdata = mem.readdata;

`ifndef SYNTHESIS
    a_req_held: assert property (@(posedge clock) disable iff (reset)
        (state_q != ARB_IDLE) |-> ((grant_q == GRANT_D) ? d_req : i_req));
    a_icache_read_only: assert property (@(posedge clock) disable iff (reset)
        !icache.write);
    a_dcache_exclusive: assert property (@(posedge clock) disable iff (reset)
        !(dcache.read && dcache.write));
`endif

endmodule
